rob_queue: RTL

Parametrised reorder buffer for the LC-3b Tomasulo core. It sits between issue control, the CDB broadcast ports and write-results control. It allocates in-order entries at issue and captures results from up to `CDB_PORTS` simultaneous broadcasts. It exposes two operand-read ports for register renaming and presents the head entry for in-order commit. It supersedes the fixed single-CDB reorder buffer with configurable depth, port count and optional same-cycle CDB bypass.

---
 rtl/lc3b_types.sv | 22 ++
 rtl/rob_queue_cdb_match.sv | 27 ++
 rtl/rob_queue.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions, including the reorder-buffer entry payload.
package lc3b_types;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned REG_W    = 3;

    typedef logic [WORD_W-1:0]   lc3b_word;
    typedef logic [OPCODE_W-1:0] lc3b_opcode;
    typedef logic [REG_W-1:0]    lc3b_reg;

    typedef struct packed {
        logic       busy;
        logic       ready;
        lc3b_opcode opcode;
        lc3b_reg    dest;
        lc3b_word   value;
        logic       predict;
        lc3b_word   pc;
    } rob_entry_t;

endpackage

// File: rtl/rob_queue_cdb_match.sv
// Lowest-port-first match of one ROB tag against all CDB broadcast ports.
module rob_cdb_match #(
    parameter int unsigned CDB_PORTS = 2,
    parameter int unsigned TAGW      = 3,
    parameter int unsigned WIDTH     = 16
) (
    input  logic [TAGW-1:0]            tag,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAGW-1:0]  cdb_tag,
    input  logic [CDB_PORTS*WIDTH-1:0] cdb_value,
    output logic                       hit,
    output logic [WIDTH-1:0]           value
);

    // Scan from the highest port down so the lowest matching port wins.
    always_comb begin
        hit   = 1'b0;
        value = '0;
        for (int p = int'(CDB_PORTS) - 1; p >= 0; p--) begin
            if (cdb_valid[p] && (cdb_tag[p*TAGW +: TAGW] == tag)) begin
                hit   = 1'b1;
                value = cdb_value[p*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/rob_queue.sv
// Parametrised reorder buffer: in-order alloc/commit, multi-port CDB capture.
// Optional same-cycle CDB bypass on read/head outputs via ROB_CDB_BYPASS_EN.
module rob_queue
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CDB_PORTS = 2,
    parameter int unsigned WIDTH     = 16,
    localparam int unsigned TAGW     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       alloc_valid,
    input  logic [3:0]                 alloc_opcode,
    input  logic [2:0]                 alloc_dest,
    input  logic [WIDTH-1:0]           alloc_value,
    input  logic                       alloc_ready,
    input  logic                       alloc_predict,
    input  logic [WIDTH-1:0]           alloc_pc,
    output logic [TAGW-1:0]            alloc_tag,
    output logic                       full,
    output logic                       empty,
    output logic [TAGW:0]              count,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAGW-1:0]  cdb_tag,
    input  logic [CDB_PORTS*WIDTH-1:0] cdb_value,
    input  logic [2*TAGW-1:0]          rd_tag,
    output logic [2*WIDTH-1:0]         rd_value,
    output logic [1:0]                 rd_ready,
    output logic                       head_valid,
    output logic [TAGW-1:0]            head_tag,
    output logic [3:0]                 head_opcode,
    output logic [2:0]                 head_dest,
    output logic [WIDTH-1:0]           head_value,
    output logic                       head_predict,
    output logic [WIDTH-1:0]           head_pc,
    input  logic                       commit
);

    localparam int unsigned PTRW = TAGW + 1;

    logic [PTRW-1:0]  head_ptr;
    logic [PTRW-1:0]  tail_ptr;
    logic [TAGW-1:0]  head_idx;
    logic [TAGW-1:0]  tail_idx;
    rob_entry_t       entries [DEPTH];
    rob_entry_t       he;
    logic [DEPTH-1:0] hit_e;
    logic [WIDTH-1:0] val_e [DEPTH];
    logic             alloc_acc;
    logic             commit_acc;

    assign head_idx   = head_ptr[TAGW-1:0];
    assign tail_idx   = tail_ptr[TAGW-1:0];
    assign empty      = (head_ptr == tail_ptr);
    assign full       = (head_idx == tail_idx) && (head_ptr[TAGW] != tail_ptr[TAGW]);
    assign count      = tail_ptr - head_ptr;
    assign alloc_tag  = tail_idx;
    assign alloc_acc  = alloc_valid & ~full;
    assign commit_acc = commit & head_valid;

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_ent
        rob_cdb_match #(.CDB_PORTS(CDB_PORTS), .TAGW(TAGW), .WIDTH(WIDTH)) u_match (
            .tag       (TAGW'(g)),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_value (cdb_value),
            .hit       (hit_e[g]),
            .value     (val_e[g])
        );
    end

    // Alloc wins over any broadcast to the tail slot; commit masks the head slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) entries[i] <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i].busy  <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            if (alloc_acc)  tail_ptr <= tail_ptr + PTRW'(1);
            if (commit_acc) head_ptr <= head_ptr + PTRW'(1);
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (alloc_acc && (tail_idx == TAGW'(i))) begin
                    entries[i].busy    <= 1'b1;
                    entries[i].ready   <= alloc_ready;
                    entries[i].opcode  <= alloc_opcode;
                    entries[i].dest    <= alloc_dest;
                    entries[i].value   <= lc3b_word'(alloc_value);
                    entries[i].predict <= alloc_predict;
                    entries[i].pc      <= lc3b_word'(alloc_pc);
                end else if (commit_acc && (head_idx == TAGW'(i))) begin
                    entries[i].busy  <= 1'b0;
                    entries[i].ready <= 1'b0;
                end else if (entries[i].busy && hit_e[i]) begin
                    entries[i].value <= lc3b_word'(val_e[i]);
                    entries[i].ready <= 1'b1;
                end
            end
        end
    end

    assign he           = entries[head_idx];
    assign head_tag     = head_idx;
    assign head_opcode  = he.opcode;
    assign head_dest    = he.dest;
    assign head_predict = he.predict;
    assign head_pc      = WIDTH'(he.pc);

`ifdef ROB_CDB_BYPASS_EN
    logic             hit_h;
    logic [WIDTH-1:0] val_h;

    rob_cdb_match #(.CDB_PORTS(CDB_PORTS), .TAGW(TAGW), .WIDTH(WIDTH)) u_head_match (
        .tag       (head_idx),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .hit       (hit_h),
        .value     (val_h)
    );

    assign head_valid = he.busy & (he.ready | hit_h);
    assign head_value = (he.busy & hit_h) ? val_h : WIDTH'(he.value);
`else
    assign head_valid = he.busy & he.ready;
    assign head_value = WIDTH'(he.value);
`endif

    for (genvar r = 0; r < 2; r++) begin : g_rd
        rob_entry_t re;
        assign re = entries[rd_tag[r*TAGW +: TAGW]];
`ifdef ROB_CDB_BYPASS_EN
        logic             rh;
        logic [WIDTH-1:0] rv;

        rob_cdb_match #(.CDB_PORTS(CDB_PORTS), .TAGW(TAGW), .WIDTH(WIDTH)) u_rd_match (
            .tag       (rd_tag[r*TAGW +: TAGW]),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_value (cdb_value),
            .hit       (rh),
            .value     (rv)
        );

        assign rd_ready[r]                = re.busy & (re.ready | rh);
        assign rd_value[r*WIDTH +: WIDTH] = (re.busy & rh) ? rv : WIDTH'(re.value);
`else
        assign rd_ready[r]                = re.busy & re.ready;
        assign rd_value[r*WIDTH +: WIDTH] = WIDTH'(re.value);
`endif
    end

endmodule
